// File: rtl/timer_unit_pkg.sv
// Shared register offsets, FSM state codes and CTRL.MODE encodings for the countdown timer.
package timer_unit_pkg;

  localparam logic [3:0] TMR_CTRL     = 4'h0;
  localparam logic [3:0] TMR_PRESET   = 4'h4;
  localparam logic [3:0] TMR_COUNT    = 4'h8;
  localparam logic [3:0] TMR_PRESCALE = 4'hC;

  localparam logic [1:0] TMR_MODE_ONESHOT = 2'b00;
  localparam logic [1:0] TMR_MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    TMR_IDLE = 2'd0,
    TMR_LOAD = 2'd1,
    TMR_CNT  = 2'd2,
    TMR_INT  = 2'd3
  } tmr_state_e;

  // Only 01 reloads; 00 and the reserved 1x codes behave as one-shot.
  function automatic logic mode_reloads(input logic [1:0] mode);
    return mode == TMR_MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the count enable: tick_o pulses once every prescale_i+1 cycles, phase restarted by restart_i.
module timer_prescaler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart_i,
  input  logic [15:0] prescale_i,
  output logic        tick_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = 1'b0;
    cnt_d  = cnt_q;
    if (restart_i) begin
      cnt_d = prescale_i;
    end else if (cnt_q == 16'd0) begin
      tick_o = 1'b1;
      cnt_d  = prescale_i;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 16'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timer_unit.sv
// Memory-mapped countdown timer with level interrupt; combinational read port for same-cycle CPU loads.
// Optional PRESCALE register and count divider when TIMER_PRESCALE_EN is defined.
module timer_unit
  import timer_unit_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_7F00,
  parameter logic [31:0] RESET_PRESET = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        irq
);

  tmr_state_e  state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;
  logic        wr_ok, wr_ctrl, wr_preset;
  logic        tick;
  logic        reload;

  assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_ok     = hit && we && (byteen == 4'b1111);
  assign wr_ctrl   = wr_ok && (addr[3:0] == TMR_CTRL);
  assign wr_preset = wr_ok && (addr[3:0] == TMR_PRESET);
  assign reload    = mode_reloads(ctrl_q[2:1]);
  assign irq       = ctrl_q[3] && flag_q;

`ifdef TIMER_PRESCALE_EN
  logic [15:0] prescale_q;
  logic        wr_prescale;
  logic        restart;

  assign wr_prescale = wr_ok && (addr[3:0] == TMR_PRESCALE);
  assign restart     = (state_q == TMR_LOAD) || (state_q == TMR_INT && reload && ctrl_q[0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           prescale_q <= 16'd0;
    else if (wr_prescale) prescale_q <= wdata[15:0];
  end

  timer_prescaler u_prescaler (
    .clk        (clk),
    .rst_n      (reset),
    .restart_i  (restart),
    .prescale_i (prescale_q),
    .tick_o     (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    count_d  = count_q;
    flag_d   = flag_q;
    preset_d = preset_q;
    case (state_q)
      TMR_IDLE: if (ctrl_q[0]) state_d = TMR_LOAD;
      TMR_LOAD: begin
        count_d = preset_q;
        state_d = TMR_CNT;
      end
      TMR_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = TMR_IDLE;
        end else if (count_q == 32'd0) begin
          flag_d  = 1'b1;
          state_d = TMR_INT;
        end else if (tick) begin
          count_d = count_q - 32'd1;
        end
      end
      TMR_INT: begin
        // Reload folds the LOAD step in here so the pulse period is PRESET+2 cycles.
        if (reload) begin
          flag_d = 1'b0;
          if (ctrl_q[0]) begin
            count_d = preset_q;
            state_d = TMR_CNT;
          end else begin
            state_d = TMR_IDLE;
          end
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = TMR_IDLE;
        end
      end
      default: state_d = TMR_IDLE;
    endcase
    // CPU writes take precedence over the FSM's own updates in the same cycle.
    if (wr_ctrl)   ctrl_d   = wdata[3:0];
    if (wr_preset) preset_d = wdata;
    if (wr_ctrl || wr_preset) flag_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= TMR_IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= RESET_PRESET;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (addr[3:0])
        TMR_CTRL:     rdata = {28'd0, ctrl_q};
        TMR_PRESET:   rdata = preset_q;
        TMR_COUNT:    rdata = count_q;
`ifdef TIMER_PRESCALE_EN
        TMR_PRESCALE: rdata = {16'd0, prescale_q};
`endif
        default:      rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_unit.sv
// Directed bench for timer_unit: register-access vector table plus cycle-exact FSM/irq sequences.
module tb_timer_unit;
  import timer_unit_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_7F00;
`ifdef TIMER_PRESCALE_EN
  localparam logic [31:0] PS_EXP = 32'h77;
`else
  localparam logic [31:0] PS_EXP = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata, v;
  logic        we, hit, irq;
  logic [3:0]  byteen;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [3:0]  be;
    logic [31:0] d;
    logic        eh;
    logic [31:0] er;
  } vec_t;
  vec_t vq[$];

  timer_unit #(.BASE_ADDR(BASE), .RESET_PRESET(32'd0)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .byteen(byteen),
    .wdata(wdata), .hit(hit), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; byteen = 4'hF; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    addr = a; we = 1'b0;
    #1;
    r = rdata;
  endtask

  function automatic logic [31:0] ctrl_w(input logic im, input logic [1:0] mode, input logic en);
    return {28'd0, im, mode, en};
  endfunction

  task automatic vec(input logic [31:0] a, input logic w, input logic [3:0] be,
                     input logic [31:0] d, input logic eh, input logic [31:0] er);
    vec_t t;
    t.a = a; t.w = w; t.be = be; t.d = d; t.eh = eh; t.er = er;
    vq.push_back(t);
  endtask

  initial begin
    logic [31:0] exp_cnt;
    reset = 1'b0; we = 1'b0; addr = BASE; wdata = '0; byteen = 4'hF;
    #22 reset = 1'b1;
    step();
    check("reset irq", {31'd0, irq}, 32'd0);

    // {addr, we, byteen, wdata, exp hit, exp rdata (value before the edge)}
    vec(BASE + TMR_CTRL,     0, 4'hF, 32'h0,         1, 32'h0);
    vec(BASE + TMR_PRESET,   0, 4'hF, 32'h0,         1, 32'h0);
    vec(BASE + TMR_COUNT,    0, 4'hF, 32'h0,         1, 32'h0);
    vec(BASE + TMR_PRESCALE, 0, 4'hF, 32'h0,         1, 32'h0);
    vec(BASE + TMR_PRESET,   1, 4'hF, 32'h12345678,  1, 32'h0);
    vec(BASE + TMR_PRESET,   0, 4'hF, 32'h0,         1, 32'h12345678);
    vec(BASE + TMR_PRESET,   1, 4'h3, 32'hAAAA5555,  1, 32'h12345678);
    vec(BASE + TMR_PRESET,   0, 4'hF, 32'h0,         1, 32'h12345678);
    vec(BASE + TMR_COUNT,    1, 4'hF, 32'h0000DEAD,  1, 32'h0);
    vec(BASE + TMR_COUNT,    0, 4'hF, 32'h0,         1, 32'h0);
    vec(BASE + 32'h20,       1, 4'hF, 32'hFFFFFFFF,  0, 32'h0);
    vec(BASE + TMR_PRESET,   0, 4'hF, 32'h0,         1, 32'h12345678);
    vec(BASE + TMR_CTRL,     0, 4'hF, 32'h0,         1, 32'h0);
    vec(BASE + TMR_CTRL,     1, 4'hF, 32'h6,         1, 32'h0);
    vec(BASE + TMR_CTRL,     0, 4'hF, 32'h0,         1, 32'h6);
    vec(BASE + TMR_CTRL,     1, 4'hF, 32'hFFFFFFF0,  1, 32'h6);
    vec(BASE + TMR_CTRL,     0, 4'hF, 32'h0,         1, 32'h0);
    vec(BASE + TMR_PRESCALE, 1, 4'hF, 32'h77,        1, 32'h0);
    vec(BASE + TMR_PRESCALE, 0, 4'hF, 32'h0,         1, PS_EXP);
    vec(32'h0000_7F10,       0, 4'hF, 32'h0,         0, 32'h0);
    vec(BASE + 32'h1,        0, 4'hF, 32'h0,         1, 32'h0);

    foreach (vq[i]) begin
      addr = vq[i].a; we = vq[i].w; byteen = vq[i].be; wdata = vq[i].d;
      #1;
      check($sformatf("vec%0d hit", i), {31'd0, hit}, {31'd0, vq[i].eh});
      check($sformatf("vec%0d rdata", i), rdata, vq[i].er);
      step();
      we = 1'b0; byteen = 4'hF;
    end

    // Reset asserted while counting with COUNT=5
    wr(BASE + TMR_PRESET, 32'd10);
    wr(BASE + TMR_CTRL, ctrl_w(1'b1, TMR_MODE_ONESHOT, 1'b1));
    for (int k = 1; k <= 7; k++) step();
    rd(BASE + TMR_COUNT, v);  check("t1 count before reset", v, 32'd5);
    reset = 1'b0;
    #1;
    check("t1 irq in reset", {31'd0, irq}, 32'd0);
    rd(BASE + TMR_COUNT, v);  check("t1 count in reset", v, 32'd0);
    rd(BASE + TMR_CTRL, v);   check("t1 ctrl in reset", v, 32'd0);
    rd(BASE + TMR_PRESET, v); check("t1 preset in reset", v, 32'd0);
    step(); step();
    #2 reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("t1 irq after release k=%0d", k), {31'd0, irq}, 32'd0);
    end
    rd(BASE + TMR_COUNT, v);  check("t1 count idle", v, 32'd0);

    // One-shot: PRESET=3, irq after E0+6, held until PRESET write
    wr(BASE + TMR_PRESET, 32'd3);
    wr(BASE + TMR_CTRL, ctrl_w(1'b1, TMR_MODE_ONESHOT, 1'b1));
    for (int k = 1; k <= 6; k++) begin
      step();
      case (k)
        1: exp_cnt = 32'd0;
        2: exp_cnt = 32'd3;
        3: exp_cnt = 32'd2;
        4: exp_cnt = 32'd1;
        default: exp_cnt = 32'd0;
      endcase
      rd(BASE + TMR_COUNT, v);
      check($sformatf("t2 count k=%0d", k), v, exp_cnt);
      check($sformatf("t2 irq k=%0d", k), {31'd0, irq}, {31'd0, k == 6});
    end
    step();
    rd(BASE + TMR_CTRL, v); check("t2 ctrl EN cleared", v, 32'h8);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("t2 irq held k=%0d", k), {31'd0, irq}, 32'd1);
    end
    wr(BASE + TMR_PRESET, 32'd2);
    check("t2 irq cleared by PRESET write", {31'd0, irq}, 32'd0);

    // Auto-reload: PRESET=2, one-cycle pulses every 4 cycles
    wr(BASE + TMR_CTRL, ctrl_w(1'b1, TMR_MODE_RELOAD, 1'b1));
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 1) exp_cnt = 32'd0;
      else begin
        case ((k - 2) % 4)
          0: exp_cnt = 32'd2;
          1: exp_cnt = 32'd1;
          default: exp_cnt = 32'd0;
        endcase
      end
      rd(BASE + TMR_COUNT, v);
      check($sformatf("t3 count k=%0d", k), v, exp_cnt);
      check($sformatf("t3 irq k=%0d", k), {31'd0, irq}, {31'd0, (k >= 5) && ((k - 5) % 4 == 0)});
    end
    wr(BASE + TMR_CTRL, 32'd0);
    for (int k = 1; k <= 3; k++) step();

    // EN cleared mid-count freezes COUNT at 7; re-enable restarts via LOAD
    wr(BASE + TMR_PRESET, 32'd10);
    wr(BASE + TMR_CTRL, ctrl_w(1'b1, TMR_MODE_ONESHOT, 1'b1));
    for (int k = 1; k <= 4; k++) step();
    rd(BASE + TMR_COUNT, v); check("t4 count before disable", v, 32'd8);
    wr(BASE + TMR_CTRL, ctrl_w(1'b1, TMR_MODE_ONESHOT, 1'b0));
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("t4 irq k=%0d", k), {31'd0, irq}, 32'd0);
    end
    rd(BASE + TMR_COUNT, v); check("t4 count frozen", v, 32'd7);
    rd(BASE + TMR_CTRL, v);  check("t4 ctrl", v, 32'h8);
    wr(BASE + TMR_CTRL, ctrl_w(1'b1, TMR_MODE_ONESHOT, 1'b1));
    step(); step();
    rd(BASE + TMR_COUNT, v); check("t4 reload after re-enable", v, 32'd10);
    wr(BASE + TMR_CTRL, 32'd0);
    for (int k = 1; k <= 3; k++) step();

`ifdef TIMER_PRESCALE_EN
    // PRESCALE=1, PRESET=2: irq after E0+7
    wr(BASE + TMR_PRESCALE, 32'd1);
    wr(BASE + TMR_PRESET, 32'd2);
    wr(BASE + TMR_CTRL, ctrl_w(1'b1, TMR_MODE_ONESHOT, 1'b1));
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("t6 irq k=%0d", k), {31'd0, irq}, {31'd0, k == 7});
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
